// File: rtl/alarm_pkg.sv
// ============================================================================
// Package : alarm_pkg
// Types, segment codes and digit indices for the alarm clock display path.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package alarm_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;
  typedef logic [1:0] dig_idx_t;

  // Segment order {g,f,e,d,c,b,a}, active high
  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_DASH  = 7'h40;
  localparam seg7_t SEG_BLANK = 7'h00;

  localparam dig_idx_t DIG_MIN_U = 2'd0;
  localparam dig_idx_t DIG_MIN_T = 2'd1;
  localparam dig_idx_t DIG_HR_U  = 2'd2;
  localparam dig_idx_t DIG_HR_T  = 2'd3;

  typedef struct packed {
    logic [15:0] time_bcd;
    logic        colon_en;
    logic        alarm_active;
  } snap_t;

  function automatic bcd_t digit_of(input logic [15:0] t, input dig_idx_t d);
    bcd_t r;
    case (d)
      DIG_MIN_U: r = t[3:0];
      DIG_MIN_T: r = t[7:4];
      DIG_HR_U:  r = t[11:8];
      default:   r = t[15:12];
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ============================================================================
// Module : bcd_to_seg7
// Combinational BCD nibble to 7-segment decoder; invalid nibbles show a dash.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_to_seg7
  import alarm_pkg::*;
(
  input  bcd_t  bcd_i,
  output seg7_t seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alarm_display_scan.sv
// ============================================================================
// Module : alarm_display_scan
// Multiplexed 4-digit 7-segment scan of a per-frame HH:MM snapshot with colon blink and alarm flash.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alarm_display_scan
  import alarm_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic [15:0] time_bcd,
  input  logic        colon_en,
  input  logic        alarm_active,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  dig_sel,
  output logic        frame_start
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_TERM = BLK_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  dig_idx_t         dig_idx_q, dig_idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  snap_t            snap_q, snap_d;
  seg7_t            seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       dig_sel_q, dig_sel_d;
  logic             frame_q, frame_d;

  logic  div_wrap, frame_wrap, lit, flash;
  bcd_t  cur_digit;
  seg7_t dec_seg;

  // Counters, snapshot and blink state
  always_comb begin
    div_cnt_d     = div_cnt_q;
    dig_idx_d     = dig_idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    snap_d        = snap_q;
    div_wrap      = (div_cnt_q == DIV_TERM);
    frame_wrap    = ena && div_wrap && (dig_idx_q == DIG_HR_T);
    if (ena) begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
      if (div_wrap) begin
        dig_idx_d = dig_idx_q + 1'b1;
      end
    end
    if (frame_wrap) begin
      snap_d = '{time_bcd: time_bcd, colon_en: colon_en, alarm_active: alarm_active};
      if (blink_cnt_q == BLK_TERM) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  assign cur_digit = digit_of(snap_d.time_bcd, dig_idx_d);

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  // Outputs derive from next-state so they move on the same edge as the counters
  always_comb begin
    seg_d     = SEG_BLANK;
    dp_d      = 1'b0;
    dig_sel_d = 4'b0000;
    frame_d   = frame_wrap;
    lit       = (div_cnt_d != '0);
    flash     = snap_d.alarm_active && blink_phase_d;
    if (ena && lit) begin
      dig_sel_d = 4'b0001 << dig_idx_d;
      seg_d     = dec_seg;
      if ((dig_idx_d == DIG_HR_T) && (snap_d.time_bcd[15:12] == 4'd0)) begin
        seg_d = SEG_BLANK;
      end
      dp_d = (dig_idx_d == DIG_HR_U) && snap_d.colon_en && !blink_phase_d;
      if (flash) begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_q     <= DIV_TERM;
      dig_idx_q     <= DIG_HR_T;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b0;
      dig_sel_q     <= 4'b0000;
      frame_q       <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      dig_idx_q     <= dig_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_sel_q     <= dig_sel_d;
      frame_q       <= frame_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_q;

endmodule

`default_nettype wire
